// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: default geometry and word/address types shared by the register bank files
package reg_bank_pkg;
  localparam int DEF_WIDTH = 20;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW = 4;
  typedef logic [DEF_AW-1:0] addr_t;
  typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: write/read/clear bus between the ALU datapath (master) and the register bank (slave)
interface reg_bank_if import reg_bank_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW = DEF_AW
);
  logic clr;
  logic we;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic rd_en;
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic rd_valid;
  logic err;
  modport master (output clr, we, waddr, wdata, rd_en, ra0, ra1, input rd0, rd1, rd_valid, err);
  modport slave (input clr, we, waddr, wdata, rd_en, ra0, ra1, output rd0, rd1, rd_valid, err);
endinterface

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one registered read port with range check, zero-register mask and optional forwarding (REG_BANK_BYPASS_EN)
module reg_bank_rdport import reg_bank_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW,
  parameter int ZERO_R0 = 0
) (
  input logic clk,
  input logic rst,
  input logic rd_en,
  input logic [AW-1:0] ra,
  input logic [WIDTH-1:0] mem [DEPTH],
`ifdef REG_BANK_BYPASS_EN
  input logic clr,
  input logic wr_ok,
  input logic [AW-1:0] waddr,
  input logic [WIDTH-1:0] wdata,
`endif
  output logic oor,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] val, nxt;
  // stored value of the addressed entry, forced to 0 for out-of-range or the hard-wired zero register
  always_comb begin
    oor = int'(ra) >= DEPTH;
    val = (oor || (ZERO_R0 != 0 && ra == '0)) ? '0 : mem[ra];
`ifdef REG_BANK_BYPASS_EN
    nxt = clr ? '0 : (wr_ok && waddr == ra) ? wdata : val;
`else
    nxt = val;
`endif
  end
  // output register loads only on a read request, otherwise holds
  always_ff @(posedge clk or posedge rst)
    if (rst) rd <= '0;
    else if (rd_en) rd <= nxt;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: register array with one write port, bulk clear, two registered read ports; forwarding via REG_BANK_BYPASS_EN
module reg_bank import reg_bank_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW,
  parameter int ZERO_R0 = 0
) (
  input logic clk,
  input logic rst,
  reg_bank_if.slave bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_oor, wr_ok, oor0, oor1;
  assign wr_oor = int'(bus.waddr) >= DEPTH;
  assign wr_ok = bus.we && !wr_oor && !(ZERO_R0 != 0 && bus.waddr == '0);
  // storage: clear beats a simultaneous write
  always_ff @(posedge clk or posedge rst)
    if (rst || bus.clr) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_ok) mem[bus.waddr] <= bus.wdata;
  // read-valid strobe and sticky range error; an error on a clearing edge still registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.err <= (bus.err && !bus.clr) || (bus.we && wr_oor) || (bus.rd_en && (oor0 || oor1));
    end
  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_rp0 (
    .clk(clk), .rst(rst), .rd_en(bus.rd_en), .ra(bus.ra0), .mem(mem),
`ifdef REG_BANK_BYPASS_EN
    .clr(bus.clr), .wr_ok(wr_ok), .waddr(bus.waddr), .wdata(bus.wdata),
`endif
    .oor(oor0), .rd(bus.rd0)
  );
  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_rp1 (
    .clk(clk), .rst(rst), .rd_en(bus.rd_en), .ra(bus.ra1), .mem(mem),
`ifdef REG_BANK_BYPASS_EN
    .clr(bus.clr), .wr_ok(wr_ok), .waddr(bus.waddr), .wdata(bus.wdata),
`endif
    .oor(oor1), .rd(bus.rd1)
  );
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: three bank configurations (default, zero register, depth 12) against an array reference model
module tb_reg_bank;
  import reg_bank_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  reg_bank_if #(.WIDTH(20), .AW(4)) b0 (), b1 (), b2 ();
  reg_bank #(.ZERO_R0(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  reg_bank #(.ZERO_R0(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  reg_bank #(.DEPTH(12)) d2 (.clk(clk), .rst(rst), .bus(b2));
  int total = 0, bad = 0;
  int dep[3] = '{16, 16, 12};
  bit zr[3] = '{0, 1, 0};
  word_t m[3][16], nx[3][16];
  word_t e0[3], e1[3], o0[3], o1[3];
  logic ev[3], ee[3], ov[3], oe[3];
  assign o0[0] = b0.rd0;
  assign o0[1] = b1.rd0;
  assign o0[2] = b2.rd0;
  assign o1[0] = b0.rd1;
  assign o1[1] = b1.rd1;
  assign o1[2] = b2.rd1;
  assign ov[0] = b0.rd_valid;
  assign ov[1] = b1.rd_valid;
  assign ov[2] = b2.rd_valid;
  assign oe[0] = b0.err;
  assign oe[1] = b1.err;
  assign oe[2] = b2.err;

  function automatic word_t look(int k, int a, bit post);
    if (a >= dep[k] || (zr[k] && a == 0)) return '0;
    return post ? nx[k][a] : m[k][a];
  endfunction

  task automatic chk(string tag, int k, word_t obs, word_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".rd0"}, k, o0[k], e0[k]);
      chk({tag, ".rd1"}, k, o1[k], e1[k]);
      chk({tag, ".valid"}, k, word_t'(ov[k]), word_t'(ev[k]));
      chk({tag, ".err"}, k, word_t'(oe[k]), word_t'(ee[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) m[k][a] = '0;
      e0[k] = '0;
      e1[k] = '0;
      ev[k] = 0;
      ee[k] = 0;
    end
  endtask

  task automatic drive(input logic c, input logic w, input int wa, input word_t wd,
                       input logic r, input int a0, input int a1);
    {b0.clr, b1.clr, b2.clr} = {3{c}};
    {b0.we, b1.we, b2.we} = {3{w}};
    {b0.waddr, b1.waddr, b2.waddr} = {3{4'(wa)}};
    {b0.wdata, b1.wdata, b2.wdata} = {3{wd}};
    {b0.rd_en, b1.rd_en, b2.rd_en} = {3{r}};
    {b0.ra0, b1.ra0, b2.ra0} = {3{4'(a0)}};
    {b0.ra1, b1.ra1, b2.ra1} = {3{4'(a1)}};
  endtask

  task automatic step(string tag, input logic c, input logic w, input int wa, input word_t wd,
                      input logic r, input int a0, input int a1);
    bit post;
`ifdef REG_BANK_BYPASS_EN
    post = 1;
`else
    post = 0;
`endif
    drive(c, w, wa, wd, r, a0, a1);
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) nx[k][a] = c ? '0 : m[k][a];
      if (!c && w && wa < dep[k] && !(zr[k] && wa == 0)) nx[k][wa] = wd;
      ee[k] = (ee[k] && !c) || (w && wa >= dep[k]) || (r && (a0 >= dep[k] || a1 >= dep[k]));
      ev[k] = r;
      if (r) begin
        e0[k] = look(k, a0, post);
        e1[k] = look(k, a1, post);
      end
    end
    @(posedge clk);
    m = nx;
    #1 check_all(tag);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0);
    model_reset();
    #12 rst = 0;
    #1 check_all("reset0");
    @(posedge clk);
    #1;
    step("pre", 0, 1, 5, 20'h003FF, 0, 0, 0);
    step("pre_rd", 0, 0, 0, '0, 1, 5, 5);
    drive(0, 1, 5, 20'h00011, 1, 5, 5);
    #3 rst = 1;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clk);
    #4 rst = 0;
    step("rst_rd", 0, 0, 0, '0, 1, 5, 5);
    step("wr5", 0, 1, 5, 20'h12345, 0, 0, 0);
    step("wr15", 0, 1, 15, 20'hABCDE, 0, 0, 0);
    step("rd5_15", 0, 0, 0, '0, 1, 5, 15);
    step("hold", 0, 0, 0, '0, 0, 1, 2);
    step("wr3", 0, 1, 3, 20'h00001, 0, 0, 0);
    step("coll", 0, 1, 3, 20'h00002, 1, 3, 3);
    step("coll_after", 0, 0, 0, '0, 1, 3, 5);
    step("clr_we", 1, 1, 7, 20'h55555, 1, 7, 5);
    step("rd7", 0, 0, 0, '0, 1, 7, 5);
    step("wr0", 0, 1, 0, 20'hFFFFF, 0, 0, 0);
    step("rd0", 0, 0, 0, '0, 1, 0, 0);
    step("wr13", 0, 1, 13, 20'h0BEEF, 0, 0, 0);
    step("rd14", 0, 0, 0, '0, 1, 14, 13);
    step("err_hold", 0, 0, 0, '0, 1, 0, 3);
    step("clr", 1, 0, 0, '0, 0, 0, 0);
    step("post_clr", 0, 0, 0, '0, 1, 13, 0);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
           word_t'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
